// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver with a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to expect one parity bit per frame (PARITY_ODD selects the sense).
module uart_rx_sampler #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic                          rx_ready,
  input  logic                          ovf_clr,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_rx_idle
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic                 rx_meta, rxs;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_q;
  logic                 push, push_ok, pop, full;
  logic                 push_ferr, push_perr;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [EW-1:0]        head;
  logic [AW-1:0]        wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  assign push_perr = perr_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
  assign push_perr = 1'b0;
`endif

  // All bit samples land mid-bit: START waits half a bit, every later state a full bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == '0) begin
            perr_q <= ((^shreg) ^ rxs) != PARITY_ODD[0];
            cnt    <= FULL_LOAD;
            state  <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == '0) begin
            if (bit_idx == '0) ferr_q <= ~rxs;
            if (bit_idx == LAST_STOP) begin
              state   <= IDLE;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              cnt     <= FULL_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // With one stop bit the frame error is only known in the push cycle itself.
  assign push      = (state == STOP) && (cnt == '0) && (bit_idx == LAST_STOP);
  assign push_ferr = (bit_idx == '0) ? ~rxs : ferr_q;

  assign full    = (fifo_count == FIFO_DEPTH[AW:0]);
  assign pop     = rx_valid && rx_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {shreg, push_ferr, push_perr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && full && !pop) rx_overflow <= 1'b1;
      else if (ovf_clr)         rx_overflow <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign rx_valid      = (fifo_count != '0);
  assign rx_data       = rx_valid ? head[EW-1:2] : '0;
  assign rx_frame_err  = rx_valid & head[1];
  assign rx_parity_err = rx_valid & head[0];
  assign uart_rx_idle  = (state == IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomized scoreboard bench for uart_rx_sampler: frames are serialised from
// byte-level expectations, and a monitor checks every FIFO pop against them.
module tb_uart_rx_sampler;

  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD_RATE  = 100000;
  localparam int DIV        = CLK_FREQ / BAUD_RATE;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int PARITY_ODD = 0;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        uart_rx;
  logic                        rx_ready;
  logic                        ovf_clr;
  logic [DATA_BITS-1:0]        rx_data;
  logic                        rx_valid;
  logic                        rx_frame_err;
  logic                        rx_parity_err;
  logic                        rx_overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        uart_rx_idle;

  exp_t exp_q[$];
  bit   exp_ovf = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  uart_rx_sampler #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .rx_ready     (rx_ready),
    .ovf_clr      (ovf_clr),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overflow  (rx_overflow),
    .fifo_count   (fifo_count),
    .uart_rx_idle (uart_rx_idle)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serialise one frame; the expected FIFO entry is decided before the stop bit
  // so it is queued ahead of the receiver's push.
  task automatic applyStimulus(input logic [DATA_BITS-1:0] data, input bit stop_ok, input bit pbit);
    exp_t e;
    e.data = data;
    e.ferr = ~stop_ok;
    e.perr = 1'b0;
    uart_rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < DATA_BITS; i++) begin
      uart_rx = data[i];
      wait_cycles(DIV);
    end
`ifdef UART_RX_PARITY_EN
    e.perr = (((^data) ^ pbit) != PARITY_ODD[0]);
    uart_rx = pbit;
    wait_cycles(DIV);
`endif
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
    else exp_ovf = 1'b1;
    for (int s = 0; s < STOP_BITS; s++) begin
      if (s == 0 && !stop_ok) begin
        uart_rx = 1'b0;
        wait_cycles(DIV * 3 / 4);
        uart_rx = 1'b1;
        wait_cycles(DIV - DIV * 3 / 4);
      end else begin
        uart_rx = 1'b1;
        wait_cycles(DIV);
      end
    end
    uart_rx = 1'b1;
    wait_cycles(DIV + int'($urandom_range(0, 7)));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    wait_cycles(2);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d entries still pending, expected 0", exp_q.size());
    end
  endtask

  // Scoreboard monitor: every negedge with valid and ready is exactly one pop.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_valid && rx_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_pop: got data=%0h ferr=%0b perr=%0b, expected no entry",
                 rx_data, rx_frame_err, rx_parity_err);
      end else begin
        e = exp_q.pop_front();
        if ({rx_data, rx_frame_err, rx_parity_err} !== {e.data, e.ferr, e.perr}) begin
          miscompares++;
          $display("[TB] FAIL pop_entry: got data=%0h ferr=%0b perr=%0b, expected data=%0h ferr=%0b perr=%0b",
                   rx_data, rx_frame_err, rx_parity_err, e.data, e.ferr, e.perr);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    ovf_clr  = 1'b0;
    wait_cycles(3);
    checkOutput("reset_valid", 32'(rx_valid), 0);
    checkOutput("reset_data", 32'(rx_data), 0);
    checkOutput("reset_ferr", 32'(rx_frame_err), 0);
    checkOutput("reset_perr", 32'(rx_parity_err), 0);
    checkOutput("reset_ovf", 32'(rx_overflow), 0);
    checkOutput("reset_count", 32'(fifo_count), 0);
    checkOutput("reset_idle", 32'(uart_rx_idle), 1);
    rst = 1'b0;
    wait_cycles(4);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("a5_valid", 32'(rx_valid), 1);
    checkOutput("a5_data", 32'(rx_data), 32'hA5);
    checkOutput("a5_ferr", 32'(rx_frame_err), 0);
    checkOutput("a5_count", 32'(fifo_count), 1);
    rx_ready = 1'b1;
    wait_drain(4 * DIV);

    $display("[TB] glitch of DIV/4 cycles");
    uart_rx = 1'b0;
    wait_cycles(3);
    checkOutput("glitch_busy", 32'(uart_rx_idle), 0);
    wait_cycles(DIV / 4 - 3);
    uart_rx = 1'b1;
    wait_cycles(DIV);
    checkOutput("glitch_idle", 32'(uart_rx_idle), 1);
    checkOutput("glitch_valid", 32'(rx_valid), 0);

    $display("[TB] frame error 0x3C");
    rx_ready = 1'b0;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkOutput("ferr_data", 32'(rx_data), 32'h3C);
    checkOutput("ferr_flag", 32'(rx_frame_err), 1);
    wait_cycles(DIV);
    checkOutput("ferr_idle", 32'(uart_rx_idle), 1);
    checkOutput("ferr_count", 32'(fifo_count), 1);
    rx_ready = 1'b1;
    wait_drain(4 * DIV);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames 0x07");
    rx_ready = 1'b0;
    applyStimulus(8'h07, 1'b1, 1'b0);
    checkOutput("par0_perr", 32'(rx_parity_err), 32'(PARITY_ODD == 0));
    rx_ready = 1'b1;
    wait_drain(4 * DIV);
    rx_ready = 1'b0;
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkOutput("par1_perr", 32'(rx_parity_err), 32'(PARITY_ODD != 0));
    rx_ready = 1'b1;
    wait_drain(4 * DIV);
`endif

    $display("[TB] randomized frames");
    rx_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(DATA_BITS'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    wait_drain(4 * DIV);

    $display("[TB] overflow with five frames");
    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) applyStimulus(DATA_BITS'(k), 1'b1, 1'b0);
    checkOutput("ovf_count", 32'(fifo_count), FIFO_DEPTH);
    checkOutput("ovf_flag", 32'(rx_overflow), 32'(exp_ovf));
    rx_ready = 1'b1;
    wait_drain(4 * DIV);
    checkOutput("ovf_sticky", 32'(rx_overflow), 32'(exp_ovf));
    ovf_clr = 1'b1;
    wait_cycles(1);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    checkOutput("ovf_cleared", 32'(rx_overflow), 32'(exp_ovf));

    $display("[TB] reset during data bit 3");
    uart_rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 3; i++) begin
      uart_rx = (8'h55 >> i) & 8'h01;
      wait_cycles(DIV);
    end
    uart_rx = 1'b0;
    wait_cycles(DIV / 2);
    checkOutput("midframe_busy", 32'(uart_rx_idle), 0);
    rst = 1'b1;
    uart_rx = 1'b1;
    wait_cycles(3);
    checkOutput("midframe_rst_idle", 32'(uart_rx_idle), 1);
    rst = 1'b0;
    wait_cycles(2 * DIV);
    checkOutput("midframe_count", 32'(fifo_count), 0);
    applyStimulus(8'h66, 1'b1, 1'b0);
    wait_drain(4 * DIV);
    checkOutput("final_valid", 32'(rx_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
